rhs_spi_master: RTL and testbench

SPI initiator that drives one shared MOSI/CS/SCLK bus to up to 16 RHS headstage chips and captures their 16 MISO lanes in parallel. It accepts one 32-bit command word per transaction and returns a 32-bit result word per lane. MISO sampling is delayed by a programmable number of clk cycles to compensate for cable round-trip delay. The block sits between the command sequencer and the physical headstage interface.

---
 rtl/rhs_spi_pkg.sv | 20 ++
 rtl/rhs_spi_if.sv | 30 +++
 rtl/rhs_miso_sampler.sv | 52 +++++
 rtl/rhs_spi_master.sv | 133 +++++++++++++
 tb/tb_rhs_spi_master.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rhs_spi_pkg.sv
// Shared defaults, FSM state encoding and lane packing helper for the RHS SPI master.
package rhs_spi_pkg;

   localparam int DEF_WORD_BITS = 32;
   localparam int DEF_NUM_MISO  = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      TAIL,
      CS_HOLD
   } state_t;

   // LSB position of a lane's word inside the flattened result bus.
   function automatic int lane_lsb(input int lane, input int word_bits);
      return lane * word_bits;
   endfunction

endpackage

// File: rtl/rhs_spi_if.sv
// Command/result handshake plus the physical SPI pins of the headstage bus.
interface rhs_spi_if #(
   parameter int NUM_MISO  = 16,
   parameter int WORD_BITS = 32,
   parameter int DELAY_W   = 4
) ();

   logic                          cmd_valid;
   logic                          cmd_ready;
   logic [WORD_BITS-1:0]          cmd_data;
   logic [DELAY_W-1:0]            cable_delay;
   logic                          CS;
   logic                          SCLK;
   logic                          MOSI;
   logic [NUM_MISO-1:0]           MISO;
   logic                          rx_valid;
   logic [NUM_MISO*WORD_BITS-1:0] rx_data;
   logic                          busy;

   modport master (
      input  cmd_valid, cmd_data, cable_delay, MISO,
      output cmd_ready, CS, SCLK, MOSI, rx_valid, rx_data, busy
   );

   modport slave (
      output cmd_valid, cmd_data, cable_delay, MISO,
      input  cmd_ready, CS, SCLK, MOSI, rx_valid, rx_data, busy
   );

endinterface

// File: rtl/rhs_miso_sampler.sv
// Shifts every MISO lane in on each delayed strobe and publishes the packed words on load.
module rhs_miso_sampler
   import rhs_spi_pkg::*;
#(
   parameter int NUM_MISO  = DEF_NUM_MISO,
   parameter int WORD_BITS = DEF_WORD_BITS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          strobe,
   input  logic                          load,
   input  logic [NUM_MISO-1:0]           miso,
   output logic                          done,
   output logic [NUM_MISO*WORD_BITS-1:0] rx_data
);
   localparam int CW = $clog2(WORD_BITS) + 1;

   logic [NUM_MISO-1:0][WORD_BITS-1:0] sr, sr_n;
   logic [NUM_MISO*WORD_BITS-1:0]      pack_n;
   logic [CW-1:0]                      cnt;

   // True once the final sample lands, including the cycle it is being taken.
   assign done = (cnt == CW'(WORD_BITS)) || (strobe && (cnt == CW'(WORD_BITS - 1)));

   always_comb begin
      sr_n   = sr;
      pack_n = '0;
      for (int i = 0; i < NUM_MISO; i++) begin
         if (strobe) sr_n[i] = {sr[i][WORD_BITS-2:0], miso[i]};
         pack_n[lane_lsb(i, WORD_BITS) +: WORD_BITS] = sr_n[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         cnt     <= '0;
         rx_data <= '0;
      end else begin
         if (clr) begin
            sr  <= '0;
            cnt <= '0;
         end else begin
            sr <= sr_n;
            if (strobe) cnt <= cnt + 1'b1;
         end
         if (load) rx_data <= pack_n;
      end
   end

endmodule

// File: rtl/rhs_spi_master.sv
// SPI initiator for RHS headstages: shared MOSI/CS/SCLK, parallel MISO capture with a
// per-transaction sample delay that absorbs cable round-trip time.
module rhs_spi_master
   import rhs_spi_pkg::*;
#(
   parameter int NUM_MISO       = DEF_NUM_MISO,
   parameter int WORD_BITS      = DEF_WORD_BITS,
   parameter int SCLK_HALF      = 2,
   parameter int CS_HIGH_CYCLES = 4,
   parameter int DELAY_W        = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   rhs_spi_if.master bus
);
   localparam int BW   = $clog2(WORD_BITS) + 1;
   localparam int HW   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int HC   = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
   localparam int NTAP = 2 ** DELAY_W;

   state_t               state, state_n;
   logic [HW-1:0]        half_cnt, half_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic [HC-1:0]        hold_cnt, hold_n;
   logic                 sclk_q, sclk_n;
   logic [WORD_BITS-1:0] sh, sh_n;
   logic [DELAY_W-1:0]   dly_q;
   logic [NTAP-1:1]      dl_q;
   logic [NTAP-1:0]      taps;
   logic                 rise, strobe, load, samp_done, accept, half_end, rx_valid_q;

   assign accept   = (state == IDLE) && bus.cmd_valid;
   assign half_end = (half_cnt == HW'(SCLK_HALF - 1));
   // First cycle of each SCLK high phase; tap d of the line is that pulse d cycles later.
   assign rise     = (state == SHIFT) && sclk_q && (half_cnt == '0);
   assign taps     = {dl_q, rise};
   assign strobe   = taps[dly_q];

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.CS        = !((state == SETUP) || (state == SHIFT) || (state == TAIL));
   assign bus.SCLK      = sclk_q;
   assign bus.MOSI      = sh[WORD_BITS-1];
   assign bus.rx_valid  = rx_valid_q;

   always_comb begin
      state_n = state;
      half_n  = half_cnt;
      bit_n   = bit_cnt;
      hold_n  = hold_cnt;
      sclk_n  = sclk_q;
      sh_n    = sh;
      load    = 1'b0;
      case (state)
         IDLE: if (bus.cmd_valid) begin
            state_n = SETUP;
            sh_n    = bus.cmd_data;
            half_n  = '0;
         end
         SETUP: if (half_end) begin
            state_n = SHIFT;
            half_n  = '0;
            bit_n   = '0;
            sclk_n  = 1'b1;
         end else half_n = half_cnt + 1'b1;
         SHIFT: if (!half_end) half_n = half_cnt + 1'b1;
         else begin
            half_n = '0;
            if (sclk_q) begin
               sclk_n = 1'b0;
               sh_n   = sh << 1;
               bit_n  = bit_cnt + 1'b1;
            end else if (bit_cnt != BW'(WORD_BITS)) begin
               sclk_n = 1'b1;
            end else if (samp_done) begin
               state_n = CS_HOLD;
               load    = 1'b1;
               hold_n  = '0;
            end else state_n = TAIL;
         end
         // Long cable delays keep CS low until the last delayed sample is in.
         TAIL: if (samp_done) begin
            state_n = CS_HOLD;
            load    = 1'b1;
            hold_n  = '0;
         end
         CS_HOLD: if (hold_cnt == HC'(CS_HIGH_CYCLES - 1)) state_n = IDLE;
                  else hold_n = hold_cnt + 1'b1;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         half_cnt   <= '0;
         bit_cnt    <= '0;
         hold_cnt   <= '0;
         sclk_q     <= 1'b0;
         sh         <= '0;
         dly_q      <= '0;
         dl_q       <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state      <= state_n;
         half_cnt   <= half_n;
         bit_cnt    <= bit_n;
         hold_cnt   <= hold_n;
         sclk_q     <= sclk_n;
         sh         <= sh_n;
         rx_valid_q <= load;
         if (accept) begin
            dly_q <= bus.cable_delay;
            dl_q  <= '0;
         end else dl_q <= taps[NTAP-2:0];
      end
   end

   rhs_miso_sampler #(
      .NUM_MISO (NUM_MISO),
      .WORD_BITS(WORD_BITS)
   ) u_samp (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .strobe (strobe),
      .load   (load),
      .miso   (bus.MISO),
      .done   (samp_done),
      .rx_data(bus.rx_data)
   );

endmodule

// File: tb/tb_rhs_spi_master.sv
// Random-stimulus bench for rhs_spi_master with a delayed-chip MISO model and timing reference.
module tb_rhs_spi_master;
   import rhs_spi_pkg::*;

   localparam int NM = 16, W = 32, H = 2, CSH = 4, DW = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   rhs_spi_if #(.NUM_MISO(NM), .WORD_BITS(W), .DELAY_W(DW)) bus ();

   rhs_spi_master #(
      .NUM_MISO(NM), .WORD_BITS(W), .SCLK_HALF(H), .CS_HIGH_CYCLES(CSH), .DELAY_W(DW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Chip model: each lane shifts its word out MSB first, advancing on SCLK falls,
   // and the cable adds chip_dly clk cycles before the value reaches MISO.
   logic [W-1:0]  chip_word [NM];
   logic [W-1:0]  exp_word  [NM];
   logic [NM-1:0] chip_out;
   logic [NM-1:0] pipe [16];
   logic [W-1:0]  mosi_cap = '0;
   bit            loopback = 1'b1;
   int            chip_dly = 0;
   int            falls = 0;
   int            n_chk = 0, n_pass = 0;

   always_comb begin
      chip_out = '0;
      for (int i = 0; i < NM; i++)
         if (loopback) chip_out[i] = bus.MOSI;
         else if (!bus.CS && falls < W) chip_out[i] = chip_word[i][W-1-falls];
   end

   always @(posedge clk) begin
      pipe[0] <= chip_out;
      for (int j = 1; j < 16; j++) pipe[j] <= pipe[j-1];
   end

   assign bus.MISO = (chip_dly == 0) ? chip_out : pipe[chip_dly-1];

   always @(negedge bus.SCLK) if (!bus.CS) falls = falls + 1;
   always @(posedge bus.SCLK) mosi_cap = {mosi_cap[W-2:0], bus.MOSI};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One transaction; CS rise cycle T comes from the closed-form timing rule.
   task automatic run_txn(input logic [W-1:0] cmd, input int d, input bit keep,
                          input logic [W-1:0] next_cmd, input string tag);
      int t_exp, t_sclk, t_samp, cs_rise, rxv_cyc, rxv_cnt, rdy_cyc;
      logic [NM*W-1:0] rx;
      t_sclk  = 1 + H * (2 * W + 1);
      t_samp  = (1 + H + 2 * (W - 1) * H) + d + 1;
      t_exp   = (t_sclk > t_samp) ? t_sclk : t_samp;
      cs_rise = -1; rxv_cyc = -1; rxv_cnt = 0; rdy_cyc = -1; rx = '0;
      for (int w = 0; w < 500 && !bus.cmd_ready; w++) @(negedge clk);
      falls           = 0;
      bus.cmd_valid   = 1'b1;
      bus.cmd_data    = cmd;
      bus.cable_delay = DW'(d);
      @(posedge clk);
      for (int n = 1; n < 400; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk({tag, " cs_low"}, 64'(bus.CS), 64'd0);
            chk({tag, " busy"}, 64'(bus.busy), 64'd1);
            bus.cmd_valid   = keep;
            bus.cmd_data    = next_cmd;
            bus.cable_delay = ~bus.cable_delay;
         end
         if (bus.CS && cs_rise < 0) cs_rise = n;
         if (bus.rx_valid) begin rxv_cnt++; rxv_cyc = n; rx = bus.rx_data; end
         if (bus.cmd_ready) begin rdy_cyc = n; break; end
      end
      chk({tag, " cs_rise"}, 64'(cs_rise), 64'(t_exp));
      chk({tag, " rxv_cyc"}, 64'(rxv_cyc), 64'(t_exp));
      chk({tag, " rxv_cnt"}, 64'(rxv_cnt), 64'd1);
      chk({tag, " ready_at"}, 64'(rdy_cyc), 64'(t_exp + CSH));
      chk({tag, " mosi"}, 64'(mosi_cap), 64'(cmd));
      for (int i = 0; i < NM; i++)
         chk($sformatf("%s lane%0d", tag, i), 64'(rx[i*W +: W]), 64'(exp_word[i]));
   endtask

   initial begin
      logic [W-1:0] c1, c2;
      int d, rv;
      bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cable_delay = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst CS", 64'(bus.CS), 64'd1);
      chk("rst SCLK", 64'(bus.SCLK), 64'd0);
      chk("rst MOSI", 64'(bus.MOSI), 64'd0);
      chk("rst rx_valid", 64'(bus.rx_valid), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst rx_data", 64'(bus.rx_data[63:0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst ready", 64'(bus.cmd_ready), 64'd1);

      // MOSI looped back to every lane
      loopback = 1'b1; chip_dly = 0;
      for (int i = 0; i < NM; i++) exp_word[i] = 32'hA5C30F01;
      run_txn(32'hA5C30F01, 0, 1'b0, 32'h0, "loop");

      // 3-cycle cable, matched and mismatched delay
      loopback = 1'b0; chip_dly = 3;
      for (int i = 0; i < NM; i++) begin
         chip_word[i] = 32'h1000_0000 + 32'(i);
         exp_word[i]  = chip_word[i];
      end
      run_txn($urandom, 3, 1'b0, 32'h0, "dly3");
      for (int i = 0; i < NM; i++) exp_word[i] = chip_word[i] >> 1;
      run_txn($urandom, 0, 1'b0, 32'h0, "skew");

      // Maximum cable delay stretches CS low
      chip_dly = 15;
      for (int i = 0; i < NM; i++) exp_word[i] = chip_word[i];
      run_txn($urandom, 15, 1'b0, 32'h0, "dly15");

      // Back-to-back with cmd_valid held; mid-transaction cmd_data change must not leak
      loopback = 1'b1; chip_dly = 0;
      c1 = $urandom; c2 = ~c1;
      for (int i = 0; i < NM; i++) exp_word[i] = c1;
      run_txn(c1, 0, 1'b1, c2, "b2b1");
      for (int i = 0; i < NM; i++) exp_word[i] = c2;
      run_txn(c2, 0, 1'b0, 32'h0, "b2b2");

      // Random delays and lane words
      loopback = 1'b0;
      for (int r = 0; r < 4; r++) begin
         d = $urandom_range(0, 15); chip_dly = d;
         for (int i = 0; i < NM; i++) begin
            chip_word[i] = $urandom;
            exp_word[i]  = chip_word[i];
         end
         run_txn($urandom, d, 1'b0, 32'h0, $sformatf("rnd%0d", r));
      end

      // Reset in the middle of a transaction
      loopback = 1'b1; chip_dly = 0; falls = 0;
      bus.cmd_valid = 1'b1; bus.cmd_data = $urandom; bus.cable_delay = '0;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (49) @(negedge clk);
      chk("mid CS_low", 64'(bus.CS), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("mid CS", 64'(bus.CS), 64'd1);
      chk("mid SCLK", 64'(bus.SCLK), 64'd0);
      chk("mid busy", 64'(bus.busy), 64'd0);
      chk("mid rx_data", 64'(bus.rx_data[W-1:0]), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rv = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus.rx_valid) rv++;
      end
      chk("mid no_rxv", 64'(rv), 64'd0);
      chk("mid rx_hold", 64'(bus.rx_data[2*W-1:W]), 64'd0);
      c1 = $urandom;
      for (int i = 0; i < NM; i++) exp_word[i] = c1;
      run_txn(c1, 0, 1'b0, 32'h0, "post");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
